// File: rtl/xor_net_pkg.sv
// rtl/xor_net_pkg.sv - shared states, pulse target and timeout defaults for the XOR network sequencer
package xor_net_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_L1_WAIT = 3'd1,
    ST_L2_WAIT = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  // Pulse 1 is the neuron's zero-input bypass pass after FLUSH; pulse 2 carries the real Y.
  localparam int unsigned PULSE_TARGET    = 2;
  localparam int unsigned TIMEOUT_DEFAULT = 31;
  localparam int unsigned X_SLOTS         = 4;

  function automatic int unsigned tcnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/xor_net_sequencer_if.sv
// rtl/xor_net_sequencer_if.sv - control, data and neuron handshake bundle of the XOR network sequencer
interface xor_net_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_HID      = 2
);
  import xor_net_pkg::*;

  logic                            start;
  logic [DATA_WIDTH-1:0]           x1;
  logic [DATA_WIDTH-1:0]           x2;
  logic                            busy;
  logic                            l1_run;
  logic [X_SLOTS*DATA_WIDTH-1:0]   l1_x;
  logic [N_HID-1:0]                l1_ready;
  logic [N_HID*DATA_WIDTH-1:0]     l1_y;
  logic                            l2_run;
  logic [X_SLOTS*DATA_WIDTH-1:0]   l2_x;
  logic                            l2_ready;
  logic [DATA_WIDTH-1:0]           l2_y;
  logic [DATA_WIDTH-1:0]           y;
  logic                            y_valid;
  logic                            y_ack;
  logic                            err;

  modport master (
    input  start, x1, x2, l1_ready, l1_y, l2_ready, l2_y, y_ack,
    output busy, l1_run, l1_x, l2_run, l2_x, y, y_valid, err
  );

  modport slave (
    output start, x1, x2, l1_ready, l1_y, l2_ready, l2_y, y_ack,
    input  busy, l1_run, l1_x, l2_run, l2_x, y, y_valid, err
  );

endinterface

// File: rtl/layer_ready_tracker.sv
// rtl/layer_ready_tracker.sv - per-neuron Ready pulse counters with Y capture on the real (second) pulse
module layer_ready_tracker
  import xor_net_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [N-1:0]            ready,
  input  logic [N*DATA_WIDTH-1:0] y_in,
  output logic [N*DATA_WIDTH-1:0] h,
  output logic                    all_done
);

  localparam logic [1:0] TARGET = 2'(PULSE_TARGET);

  logic [1:0]              cnt_q [N];
  logic [1:0]              cnt_d [N];
  logic [N*DATA_WIDTH-1:0] h_q;
  logic [N*DATA_WIDTH-1:0] h_d;

  // Counters saturate at TARGET so late pulses can never disturb a captured value.
  always_comb begin
    h_d      = h_q;
    all_done = 1'b1;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = 2'd0;
      end else if (en && ready[i] && (cnt_q[i] != TARGET)) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
        if ((cnt_q[i] + 2'd1) == TARGET) begin
          h_d[i*DATA_WIDTH +: DATA_WIDTH] = y_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (cnt_q[i] != TARGET) begin
        all_done = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= 2'd0;
      end
      h_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      h_q <= h_d;
    end
  end

  assign h = h_q;

endmodule

// File: rtl/xor_net_sequencer.sv
// rtl/xor_net_sequencer.sv - runs the hidden layer then the output neuron and hands the result to a consumer
module xor_net_sequencer
  import xor_net_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_HID      = 2,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  xor_net_sequencer_if.master bus
);

  localparam int unsigned    TW     = tcnt_width(TIMEOUT);
  localparam logic [TW-1:0]  TLIMIT = TW'(TIMEOUT);

  state_e                      state_q, state_d;
  logic [DATA_WIDTH-1:0]       x1_q, x1_d;
  logic [DATA_WIDTH-1:0]       x2_q, x2_d;
  logic [DATA_WIDTH-1:0]       y_q, y_d;
  logic [TW-1:0]               tcnt_q, tcnt_d;
  logic [TW-1:0]               tcnt_inc;
  logic                        trk_clr;
  logic                        l1_en;
  logic                        l2_en;
  logic [N_HID*DATA_WIDTH-1:0] l1_h;
  logic                        l1_done;
  logic [DATA_WIDTH-1:0]       l2_h;
  logic                        l2_done;
  logic [X_SLOTS*DATA_WIDTH-1:0] l1_x_w;
  logic [X_SLOTS*DATA_WIDTH-1:0] l2_x_w;

  layer_ready_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N_HID)
  ) u_l1_trk (
    .clk      (clk),
    .rst      (rst),
    .clr      (trk_clr),
    .en       (l1_en),
    .ready    (bus.l1_ready),
    .y_in     (bus.l1_y),
    .h        (l1_h),
    .all_done (l1_done)
  );

  layer_ready_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (1)
  ) u_l2_trk (
    .clk      (clk),
    .rst      (rst),
    .clr      (trk_clr),
    .en       (l2_en),
    .ready    (bus.l2_ready),
    .y_in     (bus.l2_y),
    .h        (l2_h),
    .all_done (l2_done)
  );

  always_comb begin
    state_d  = state_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    y_d      = y_q;
    tcnt_d   = tcnt_q;
    trk_clr  = 1'b0;
    l1_en    = 1'b0;
    l2_en    = 1'b0;
    tcnt_inc = tcnt_q + TW'(1);
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (bus.start) begin
          x1_d    = bus.x1;
          x2_d    = bus.x2;
          tcnt_d  = '0;
          trk_clr = 1'b1;
          state_d = ST_L1_WAIT;
        end
      end
      ST_L1_WAIT: begin
        l1_en = 1'b1;
        if (l1_done) begin
          tcnt_d  = '0;
          state_d = ST_L2_WAIT;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TLIMIT) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_L2_WAIT: begin
        l2_en = 1'b1;
        if (l2_done) begin
          y_d     = l2_h;
          state_d = ST_DONE;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TLIMIT) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DONE: begin
        if (bus.y_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x1_q    <= '0;
      x2_q    <= '0;
      y_q     <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y_q     <= y_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Unused neuron input slots are tied to zero.
  always_comb begin
    l1_x_w = '0;
    l1_x_w[DATA_WIDTH-1:0]            = x1_q;
    l1_x_w[2*DATA_WIDTH-1:DATA_WIDTH] = x2_q;
    l2_x_w = '0;
    l2_x_w[N_HID*DATA_WIDTH-1:0]      = l1_h;
  end

  assign bus.l1_x    = l1_x_w;
  assign bus.l2_x    = l2_x_w;
  assign bus.busy    = (state_q == ST_L1_WAIT) || (state_q == ST_L2_WAIT) || (state_q == ST_DONE);
  assign bus.l1_run  = (state_q == ST_L1_WAIT);
  assign bus.l2_run  = (state_q == ST_L2_WAIT);
  assign bus.y       = y_q;
  assign bus.y_valid = (state_q == ST_DONE);
  assign bus.err     = (state_q == ST_ERR);

endmodule
